data_sram_responder: RTL

//  Slave (responder) end of the SRAM-like data bus driven by the CPU's EXE/MEM stages.

---
 rtl/data_sram_if.sv | 25 ++
 rtl/data_sram_responder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/data_sram_if.sv
// SRAM-like data bus between the CPU (master) and a data memory (slave).
//   req/wr/size/wstrb/addr/wdata : request fields, driven by the master
//   addr_ok                      : request accepted this cycle (slave)
//   data_ok/rdata                : in-order completion and read word (slave)
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Responder end of the SRAM-like data bus, used as the data-side memory model.
// Requests are accepted with addr_ok, queued (up to FIFO_DEPTH outstanding) and
// completed strictly in order with data_ok no earlier than LATENCY cycles after
// the accept edge. Backed by a word-addressed RAM of 2**ADDR_WIDTH 32-bit words.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; empties the queue, RAM is kept
//   data_sram  slave modport of data_sram_if (request in, addr_ok/data_ok/rdata out)
module data_sram_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_sram_if.slave data_sram
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_M1  = LATENCY - 1;
  localparam int ONE     = 1;

  localparam logic [CNT_W-1:0]   CNT_INIT = LAT_M1[CNT_W-1:0];
  localparam logic [COUNT_W-1:0] DEPTH_C  = FIFO_DEPTH[COUNT_W-1:0];
  localparam logic [PTR_W-1:0]   PTR_ONE  = ONE[PTR_W-1:0];
  localparam logic [COUNT_W-1:0] CNT_ONE  = ONE[COUNT_W-1:0];

  // Request queue storage (data only, never reset)
  logic                  r_wr          [FIFO_DEPTH];
  logic [1:0]            r_unused_size [FIFO_DEPTH];
  logic [3:0]            r_wstrb       [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_idx         [FIFO_DEPTH];
  logic [31:0]           r_wdata       [FIFO_DEPTH];
  logic [CNT_W-1:0]      r_cnt         [FIFO_DEPTH];

  logic [31:0]           r_mem [2**ADDR_WIDTH];

  // Queue control
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [COUNT_W-1:0]    r_count;

  logic                  w_addr_ok;
  logic                  w_data_ok;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_wr;
  logic [3:0]            w_head_strb;
  logic [ADDR_WIDTH-1:0] w_head_idx;
  logic [31:0]           w_head_wdata;
  logic [31:0]           w_rdata;
  logic                  w_unused_addr;

  // Byte offset and bits above the RAM index are ignored (address aliasing).
  assign w_unused_addr = ^{data_sram.addr[31:ADDR_WIDTH+2], data_sram.addr[1:0]};

  // Accept depends only on occupancy; a pop in the same cycle does not free a slot.
  assign w_addr_ok = !reset && (r_count < DEPTH_C);
  assign w_push    = data_sram.req && w_addr_ok;

  assign w_head_wr    = r_wr[r_rd_ptr];
  assign w_head_strb  = r_wstrb[r_rd_ptr];
  assign w_head_idx   = r_idx[r_rd_ptr];
  assign w_head_wdata = r_wdata[r_rd_ptr];

  // Head completes once its latency counter has run out; no back-pressure.
  assign w_data_ok = !reset && (r_count != '0) && (r_cnt[r_rd_ptr] == '0);
  assign w_pop     = w_data_ok;

  // Reads return the RAM word directly; earlier writes have already committed.
  assign w_rdata = (w_data_ok && !w_head_wr) ? r_mem[w_head_idx] : 32'h0;

  assign data_sram.addr_ok = w_addr_ok;
  assign data_sram.data_ok = w_data_ok;
  assign data_sram.rdata   = w_rdata;

  // Stage: queue pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stage: entry capture and latency ageing.
  // Slots that are not occupied age too; harmless, since a push reloads the counter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_push && (r_wr_ptr == i[PTR_W-1:0])) begin
        r_wr[i]          <= data_sram.wr;
        r_unused_size[i] <= data_sram.size;
        r_wstrb[i]       <= data_sram.wstrb;
        r_idx[i]         <= data_sram.addr[ADDR_WIDTH+1:2];
        r_wdata[i]       <= data_sram.wdata;
        r_cnt[i]         <= CNT_INIT;
      end else if (r_cnt[i] != '0) begin
        r_cnt[i]         <= r_cnt[i] - 1'b1;
      end
    end
  end

  // Stage: write commit at the head's completion edge
  always_ff @(posedge clk) begin
    if (w_pop && w_head_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (w_head_strb[k]) r_mem[w_head_idx][8*k +: 8] <= w_head_wdata[8*k +: 8];
      end
    end
  end

endmodule
